// File: rtl/lfsr_grant_arbiter.sv
// Round-robin arbiter handing out words from one shared 16-bit Fibonacci LFSR.
// Optional LFSR_ZERO_GUARD_EN: a zero reseed is replaced by SEED so the LFSR cannot lock up.
module lfsr_grant_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            en,
    input  logic            seed_load,
    input  logic [15:0]     seed_in,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rnd_out,
    output logic            rnd_valid,
    output logic [15:0]     word_cnt,
    output logic            period_done,
    output logic            lockup,
    output logic [1:0]      state
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StLoad = 2'd2
    } state_e;

    state_e          state_q;
    logic [15:0]     lfsr_q;
    logic [15:0]     ref_q;
    logic [IW-1:0]   last_q;
    logic [NREQ-1:0] gnt_q;
    logic [15:0]     rnd_q;
    logic            valid_q;
    logic [15:0]     cnt_q;
    logic            pdone_q;

    logic [15:0]     lfsr_next;
    logic [15:0]     seed_eff;
    logic [IW-1:0]   winner;
    logic [NREQ-1:0] winner_onehot;
    logic            grant;

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef LFSR_ZERO_GUARD_EN
    assign seed_eff = (seed_in == 16'h0000) ? SEED : seed_in;
`else
    assign seed_eff = seed_in;
`endif

    // Scan downward so the nearest requester after last_q is the final (winning) assignment.
    always_comb begin
        winner = last_q;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            if (req[IW'((32'(last_q) + i) % NREQ)]) begin
                winner = IW'((32'(last_q) + i) % NREQ);
            end
        end
    end

    assign winner_onehot = NREQ'(1) << winner;
    assign grant = (state_q == StRun) && !seed_load && en && (|req);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            ref_q   <= SEED;
            last_q  <= IW'(NREQ - 1);
            gnt_q   <= '0;
            rnd_q   <= 16'h0000;
            valid_q <= 1'b0;
            cnt_q   <= 16'h0000;
            pdone_q <= 1'b0;
        end else begin
            if (seed_load) begin
                state_q <= StLoad;
            end else begin
                case (state_q)
                    StIdle:  if (en) state_q <= StRun;
                    StRun:   if (!en) state_q <= StIdle;
                    StLoad:  state_q <= en ? StRun : StIdle;
                    default: state_q <= StIdle;
                endcase
            end

            gnt_q   <= '0;
            valid_q <= 1'b0;
            pdone_q <= 1'b0;

            // A reseed takes precedence over any pending request.
            if (seed_load) begin
                lfsr_q <= seed_eff;
                ref_q  <= seed_eff;
                cnt_q  <= 16'h0000;
            end else if (grant) begin
                gnt_q   <= winner_onehot;
                rnd_q   <= lfsr_q;
                valid_q <= 1'b1;
                lfsr_q  <= lfsr_next;
                last_q  <= winner;
                cnt_q   <= cnt_q + 16'd1;
                pdone_q <= (lfsr_next == ref_q);
            end
        end
    end

    assign gnt         = gnt_q;
    assign rnd_out     = rnd_q;
    assign rnd_valid   = valid_q;
    assign word_cnt    = cnt_q;
    assign period_done = pdone_q;
    assign lockup      = (lfsr_q == 16'h0000);
    assign state       = state_q;

endmodule

// File: tb/tb_lfsr_grant_arbiter.sv
// Self-checking bench for lfsr_grant_arbiter: directed steps plus random traffic vs a reference model.
module tb_lfsr_grant_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            n_reset;
    logic            en;
    logic            seed_load;
    logic [15:0]     seed_in;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rnd_out;
    logic            rnd_valid;
    logic [15:0]     word_cnt;
    logic            period_done;
    logic            lockup;
    logic [1:0]      state;

    lfsr_grant_arbiter #(
        .NREQ(NREQ),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .en(en),
        .seed_load(seed_load),
        .seed_in(seed_in),
        .req(req),
        .gnt(gnt),
        .rnd_out(rnd_out),
        .rnd_valid(rnd_valid),
        .word_cnt(word_cnt),
        .period_done(period_done),
        .lockup(lockup),
        .state(state)
    );

    initial forever #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: state 0=idle, 1=run, 2=load
    int              m_state;
    int              m_last;
    logic [15:0]     m_lfsr;
    logic [15:0]     m_ref;
    logic [15:0]     m_cnt;
    logic [15:0]     m_rnd;
    logic [NREQ-1:0] m_gnt;
    bit              m_valid;
    bit              m_pd;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] q);
        logic [15:0] fb;
        fb = 16'($countones(q & 16'hB400) % 2);
        return (q << 1) | fb;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_last  = NREQ - 1;
        m_lfsr  = SEED;
        m_ref   = SEED;
        m_cnt   = 16'h0000;
        m_rnd   = 16'h0000;
        m_gnt   = '0;
        m_valid = 1'b0;
        m_pd    = 1'b0;
    endtask

    task automatic model_edge();
        bit              take;
        int              w;
        logic [IW-1:0]   ix;
        logic [15:0]     s;
        logic [15:0]     nxt;
        take    = (m_state == 1) && !seed_load && en && (req != '0);
        m_gnt   = '0;
        m_valid = 1'b0;
        m_pd    = 1'b0;
        if (seed_load) begin
            s = seed_in;
`ifdef LFSR_ZERO_GUARD_EN
            if (s == 16'h0000) s = SEED;
`endif
            m_lfsr = s;
            m_ref  = s;
            m_cnt  = 16'h0000;
        end else if (take) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                ix = IW'((m_last + k) % NREQ);
                if (w < 0 && req[ix]) w = (m_last + k) % NREQ;
            end
            m_gnt   = NREQ'(1) << w;
            m_rnd   = m_lfsr;
            m_valid = 1'b1;
            nxt     = lfsr_adv(m_lfsr);
            m_pd    = (nxt == m_ref);
            m_lfsr  = nxt;
            m_last  = w;
            m_cnt   = m_cnt + 16'd1;
        end
        m_state = seed_load ? 2 : (en ? 1 : 0);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt", 16'(gnt), 16'(m_gnt));
        chk("rnd_out", rnd_out, m_rnd);
        chk("rnd_valid", 16'(rnd_valid), 16'(m_valid));
        chk("word_cnt", word_cnt, m_cnt);
        chk("period_done", 16'(period_done), 16'(m_pd));
        chk("lockup", 16'(lockup), 16'(m_lfsr == 16'h0000));
        chk("state", 16'(state), 16'(m_state));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    int npd;
    int pd_at;
    int ngr;

    initial begin
        n_reset   = 1'b1;
        en        = 1'b0;
        seed_load = 1'b0;
        seed_in   = 16'h0000;
        req       = '0;
        #1;

        // Reset state, disabled: no grants
        req = 4'b0001;
        do_reset();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_lockup", 16'(lockup), 16'd0);
        chk("rst_word_cnt", word_cnt, 16'd0);
        repeat (3) begin
            cyc();
            chk("idle_no_gnt", 16'(gnt), 16'd0);
        end

        // Single requester held
        en = 1'b1;
        cyc();
        cyc();
        chk("g1_gnt", 16'(gnt), 16'h0001);
        chk("g1_rnd", rnd_out, 16'hACE1);
        chk("g1_cnt", word_cnt, 16'd1);
        cyc();
        chk("g2_rnd", rnd_out, 16'h59C3);
        chk("g2_cnt", word_cnt, 16'd2);
        cyc();
        chk("g3_rnd", rnd_out, 16'hB387);
        chk("g3_cnt", word_cnt, 16'd3);

        // Round robin across three requesters
        do_reset();
        en  = 1'b1;
        req = 4'b0111;
        cyc();
        cyc();
        chk("rr1_gnt", 16'(gnt), 16'h0001);
        chk("rr1_rnd", rnd_out, 16'hACE1);
        cyc();
        chk("rr2_gnt", 16'(gnt), 16'h0002);
        chk("rr2_rnd", rnd_out, 16'h59C3);
        cyc();
        chk("rr3_gnt", 16'(gnt), 16'h0004);
        chk("rr3_rnd", rnd_out, 16'hB387);
        cyc();
        chk("rr4_gnt", 16'(gnt), 16'h0001);

        // Reseed while requests are active
        seed_load = 1'b1;
        seed_in   = 16'h1234;
        cyc();
        chk("ld_no_gnt", 16'(gnt), 16'd0);
        chk("ld_state", 16'(state), 16'd2);
        seed_load = 1'b0;
        cyc();
        chk("ld_cycle_no_gnt", 16'(rnd_valid), 16'd0);
        cyc();
        chk("ld_first_rnd", rnd_out, 16'h1234);
        chk("ld_first_cnt", word_cnt, 16'd1);

        // Random traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            en        = ($urandom_range(0, 9) != 0);
            req       = NREQ'($urandom);
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cyc();
        end

        // Full period from SEED
        do_reset();
        en        = 1'b1;
        seed_load = 1'b0;
        req       = 4'b0001;
        npd       = 0;
        pd_at     = 0;
        ngr       = 0;
        for (int i = 0; i < 65537; i++) begin
            cyc();
            if (rnd_valid) ngr++;
            if (period_done) begin
                npd++;
                pd_at = ngr;
            end
        end
        chk("period_grants", 16'(ngr), 16'(65536));
        chk("period_pulses", 16'(npd), 16'd1);
        chk("period_at", 16'(pd_at), 16'hFFFF);
        chk("period_wrap_rnd", rnd_out, 16'hACE1);
        chk("period_wrap_cnt", word_cnt, 16'h0000);

        // Zero reseed
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        cyc();
        seed_load = 1'b0;
        cyc();
        cyc();
`ifdef LFSR_ZERO_GUARD_EN
        chk("zero_rnd", rnd_out, 16'hACE1);
        chk("zero_lockup", 16'(lockup), 16'd0);
`else
        chk("zero_rnd", rnd_out, 16'h0000);
        chk("zero_lockup", 16'(lockup), 16'd1);
        chk("zero_pd", 16'(period_done), 16'd1);
        cyc();
        chk("zero_rnd2", rnd_out, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
